// File: rtl/plot_queue.sv
// plot_queue: FIFO between processor pixel writes and the VGA adapter, with a full-screen clear sweep
// Ports: clk, reset (async, active-high)
//        plot_x/plot_y/color/plot : processor pixel push, one per cycle while plot is high
//        clear_req                : starts a sweep of every SCREEN_W x SCREEN_H pixel to colour 0
//        vga_x/vga_y/vga_colour/vga_plot : registered VGA adapter write port
//        busy : sweep in progress; full : FIFO holds DEPTH entries; overflow : sticky dropped push
// Build option: define PLOT_CLIP_EN to discard pushes outside the visible screen
module plot_queue #(
    parameter int DEPTH    = 16,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int C_W      = 3,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [X_W-1:0] plot_x,
    input  logic [Y_W-1:0] plot_y,
    input  logic [C_W-1:0] color,
    input  logic           plot,
    input  logic           clear_req,
    output logic [X_W-1:0] vga_x,
    output logic [Y_W-1:0] vga_y,
    output logic [C_W-1:0] vga_colour,
    output logic           vga_plot,
    output logic           busy,
    output logic           full,
    output logic           overflow
);
    localparam int A_W = $clog2(DEPTH);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] CLEAR = 1'b1;
    logic [X_W+Y_W+C_W-1:0] mem [DEPTH];
    logic [A_W-1:0] wr_ptr, rd_ptr;
    logic [A_W:0]   count;
    logic [0:0]     state;
    logic [X_W-1:0] cx;
    logic [Y_W-1:0] cy;
    logic in_range, accept, flush, push, pop, row_end, last;
`ifdef PLOT_CLIP_EN
    assign in_range = (32'(plot_x) < 32'(SCREEN_W)) && (32'(plot_y) < 32'(SCREEN_H));
`else
    assign in_range = 1'b1;
`endif
    assign full    = count == (A_W+1)'(DEPTH);
    assign accept  = plot & in_range;
    assign flush   = (state == IDLE) & clear_req;
    assign push    = accept & ~full & ~flush;
    assign pop     = (state == IDLE) & ~clear_req & (count != '0);
    assign row_end = cx == X_W'(SCREEN_W - 1);
    assign last    = row_end & (cy == Y_W'(SCREEN_H - 1));
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {plot_x, plot_y, color};
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            state      <= IDLE;
            cx         <= '0;
            cy         <= '0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
            busy       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr + A_W'(push);
            // flushing realigns the read pointer so the emptied FIFO stays consistent
            rd_ptr   <= flush ? wr_ptr : rd_ptr + A_W'(pop);
            count    <= flush ? '0 : count + (A_W+1)'(push) - (A_W+1)'(pop);
            overflow <= flush ? 1'b0 : overflow | (accept & full);
            if (state == CLEAR) begin
                vga_x      <= cx;
                vga_y      <= cy;
                vga_colour <= '0;
                vga_plot   <= 1'b1;
                cx         <= row_end ? '0 : cx + 1'b1;
                cy         <= row_end ? cy + 1'b1 : cy;
                state      <= last ? IDLE : CLEAR;
                busy       <= ~last;
            end else begin
                vga_plot <= pop;
                if (pop) {vga_x, vga_y, vga_colour} <= mem[rd_ptr];
                if (clear_req) begin
                    state <= CLEAR;
                    busy  <= 1'b1;
                    cx    <= '0;
                    cy    <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_plot_queue.sv
// tb_plot_queue: directed table and corner-case sequences for plot_queue
module tb_plot_queue;
    logic       clk = 1'b0, reset = 1'b0;
    logic [7:0] plot_x = '0;
    logic [6:0] plot_y = '0;
    logic [2:0] color = '0;
    logic       plot = 1'b0, clear_req = 1'b0;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot, busy, full, overflow;
    int tests = 0, fails = 0;
    logic [17:0] log_q[$];
    plot_queue dut (
        .clk(clk), .reset(reset), .plot_x(plot_x), .plot_y(plot_y), .color(color),
        .plot(plot), .clear_req(clear_req), .vga_x(vga_x), .vga_y(vga_y),
        .vga_colour(vga_colour), .vga_plot(vga_plot), .busy(busy), .full(full),
        .overflow(overflow)
    );
    always #5 clk = ~clk;
    always @(negedge clk) if (vga_plot) log_q.push_back({vga_x, vga_y, vga_colour});
    typedef struct {
        logic       p;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        logic       e_plot;
        logic [7:0] e_x;
        logic [6:0] e_y;
        logic [2:0] e_c;
    } vec_t;
    vec_t tbl[8];
    function automatic vec_t mk(logic p, logic [7:0] x, logic [6:0] y, logic [2:0] c,
                                logic ep, logic [7:0] ex, logic [6:0] ey, logic [2:0] ec);
        vec_t v;
        v.p = p; v.x = x; v.y = y; v.c = c;
        v.e_plot = ep; v.e_x = ex; v.e_y = ey; v.e_c = ec;
        return v;
    endfunction
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic push_px(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
        plot = 1'b1; plot_x = x; plot_y = y; color = c;
        tick();
        plot = 1'b0;
    endtask
    initial begin
        int n, bad, sz;
        logic [17:0] e;
        tbl[0] = mk(1, 10, 20, 5, 0, 0, 0, 0);
        tbl[1] = mk(0, 0, 0, 0, 1, 10, 20, 5);
        tbl[2] = mk(0, 0, 0, 0, 0, 10, 20, 5);
        tbl[3] = mk(1, 1, 2, 3, 0, 10, 20, 5);
        tbl[4] = mk(1, 4, 5, 6, 1, 1, 2, 3);
        tbl[5] = mk(1, 159, 119, 7, 1, 4, 5, 6);
        tbl[6] = mk(0, 0, 0, 0, 1, 159, 119, 7);
        tbl[7] = mk(0, 0, 0, 0, 0, 159, 119, 7);
        #1 reset = 1'b1;
        #1 chk("reset_outputs", {14'b0, vga_plot, busy, full, overflow, vga_x, vga_y, vga_colour}, 0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            plot = tbl[i].p; plot_x = tbl[i].x; plot_y = tbl[i].y; color = tbl[i].c;
            tick();
            chk($sformatf("vec%0d", i), {11'b0, busy, full, overflow, vga_plot, vga_x, vga_y, vga_colour},
                {14'b0, tbl[i].e_plot, tbl[i].e_x, tbl[i].e_y, tbl[i].e_c});
        end
        plot = 1'b0;
        // clear sweep with a burst pushed behind it and clear_req held high
        log_q.delete();
        clear_req = 1'b1;
        tick();
        chk("clear_busy", {31'b0, busy}, 1);
        for (int i = 0; i < 20; i++) begin
            push_px(8'(i + 1), 7'(i + 2), 3'((i % 7) + 1));
            if (i == 14) chk("not_full_15", {31'b0, full}, 0);
            if (i == 15) chk("full_16", {31'b0, full}, 1);
            if (i == 15) chk("no_ovf_16", {31'b0, overflow}, 0);
            if (i == 16) chk("ovf_17", {31'b0, overflow}, 1);
        end
        repeat (40) tick();
        clear_req = 1'b0;
        n = 0;
        while (busy && n < 20000) begin
            tick();
            n++;
        end
        chk("clear_done_in_time", {31'b0, busy}, 0);
        repeat (25) tick();
        chk("log_size", log_q.size(), 19216);
        bad = 0;
        for (int k = 0; k < 19200 && k < log_q.size(); k++)
            if (log_q[k] !== {8'(k % 160), 7'(k / 160), 3'd0}) bad++;
        chk("sweep_pixels", bad, 0);
        if (log_q.size() > 0) chk("sweep_first", log_q[0], 0);
        if (log_q.size() > 19199) chk("sweep_last", log_q[19199], {8'd159, 7'd119, 3'd0});
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            e = {8'(i + 1), 7'(i + 2), 3'((i % 7) + 1)};
            if (log_q.size() <= 19200 + i || log_q[19200 + i] !== e) bad++;
        end
        chk("burst_order", bad, 0);
        chk("ovf_sticky", {31'b0, overflow}, 1);
        chk("drained_not_full", {31'b0, full}, 0);
        // second clear clears overflow, then reset in the middle of it
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        chk("clear_clears_ovf", {30'b0, overflow, busy}, 1);
        log_q.delete();
        n = 0;
        while (log_q.size() < 500 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("reached_500", {31'b0, log_q.size() >= 500}, 1);
        #2 reset = 1'b1;
        #1 chk("async_reset_mid_clear", {14'b0, vga_plot, busy, full, overflow, vga_x, vga_y, vga_colour}, 0);
        tick();
        reset = 1'b0;
        sz = log_q.size();
        repeat (20) tick();
        chk("no_resume", log_q.size(), sz);
        chk("idle_after_reset", {31'b0, busy}, 0);
        // clip boundary
        log_q.delete();
        push_px(160, 5, 1);
        push_px(5, 120, 2);
        push_px(159, 119, 3);
        repeat (5) tick();
`ifdef PLOT_CLIP_EN
        chk("clip_count", log_q.size(), 1);
        if (log_q.size() > 0) chk("clip_kept", log_q[0], {8'd159, 7'd119, 3'd3});
`else
        chk("noclip_count", log_q.size(), 3);
        if (log_q.size() > 2) begin
            chk("noclip_0", log_q[0], {8'd160, 7'd5, 3'd1});
            chk("noclip_1", log_q[1], {8'd5, 7'd120, 3'd2});
            chk("noclip_2", log_q[2], {8'd159, 7'd119, 3'd3});
        end
`endif
        chk("clip_no_ovf", {31'b0, overflow}, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
